dtree_seq_classifier: RTL and testbench
=======================================

Name: dtree_seq_classifier

Overview:
- Sequential, table-driven decision-tree classifier; generalises the fixed single-feature combinational trees to N features, runtime-loadable node table and bounded depth.
- Walks one tree node per clock from root (node 0) to a leaf and emits that leaf's class.
- Feature vector in via valid/ready handshake; result out via valid/ready handshake. Node table written through a config port.

Parameters:
- NUM_FEATURES, 16, number of input features.
- FEAT_W, 8, feature and threshold width (unsigned).
- CLASS_W, 4, class output width; must be <= FEAT_W.
- NODE_AW, 6, node address width; table holds 2**NODE_AW nodes.
- MAX_DEPTH, 8, maximum internal nodes evaluated per classification.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  node table write strobe.
- cfg_addr  in  NODE_AW  node index to write.
- cfg_wdata  in  NODE_W  node word; NODE_W = 1+FIW+FEAT_W+2*NODE_AW, FIW = max(1,$clog2(NUM_FEATURES)).
- cfg_ready  out  1  high when writes are accepted (state IDLE).
- in_valid  in  1  feature vector valid.
- in_ready  out  1  block can accept a vector.
- in_feat  in  NUM_FEATURES*FEAT_W  feature i at bits [i*FEAT_W +: FEAT_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_class  out  CLASS_W  predicted class.
- out_err  out  1  classification aborted (depth overrun or bad feature index).

Behaviour:
- Node word, MSB to LSB: leaf(1) | feat_idx(FIW) | thr(FEAT_W) | left(NODE_AW) | right(NODE_AW). Leaf class = thr[CLASS_W-1:0].
- Node table is a register array, combinational read, not reset (contents undefined until written).
- Reset: state IDLE, out_valid=0, out_class=0, out_err=0, in_ready=1, cfg_ready=1, pointer=0, depth=0. Reset mid-walk abandons the walk; no output produced; node table unaffected.
- States IDLE, WALK, DONE.
- IDLE: in_ready=1. in_valid&in_ready latches in_feat, ptr=0, depth=0 -> WALK. Config writes take effect only in IDLE; cfg_we in WALK/DONE is ignored. A write and an accept in the same cycle are both performed; the walk sees the new contents.
- WALK (one node per cycle, node = table[ptr]):
  - leaf=1: out_class=leaf class, out_err=0 -> DONE.
  - leaf=0 and depth==MAX_DEPTH: out_class=0, out_err=1 -> DONE.
  - leaf=0 and feat_idx>=NUM_FEATURES: out_class=0, out_err=1 -> DONE.
  - else: if feat[feat_idx] <= thr (unsigned, inclusive) ptr=left else ptr=right; depth+=1.
- DONE: out_valid=1, outputs stable until out_ready; on out_valid&out_ready -> IDLE (in_ready high the following cycle).
- Latency: leaf reached after d internal nodes -> out_valid high d+1 cycles after accept edge. Worst case MAX_DEPTH+1.
- in_ready=0 in WALK and DONE; in_feat ignored there.
- Depth counter width $clog2(MAX_DEPTH+1); saturating is not needed because the overrun check precedes the increment.

Optional Feature:
- Macro DTREE_PATH_TRACE_EN.
- Defined: extra output out_depth ($clog2(MAX_DEPTH+1) bits) = internal nodes evaluated for the current result, valid with out_valid, reset 0; plus out_leaf (NODE_AW) = index of final node evaluated, reset 0.
- Not defined: ports absent; all other behaviour identical.

Test Plan:
- Load tree: n0{feat2,thr100,L1,R2}, n1{leaf,class5}, n2{feat0,thr200,L3,R4}, n3{leaf,7}, n4{leaf,9}; X2=100 -> out_class=5, out_err=0, out_valid 2 cycles after accept.
- Same tree, X2=101, X0=200 -> class 7 after 3 cycles; X0=201 -> class 9 after 3 cycles (threshold inclusivity both sides).
- n0{feat0,thr255,L0,R0} (self-loop), MAX_DEPTH=8 -> out_err=1, out_class=0, out_valid 9 cycles after accept.
- n0 feat_idx=NUM_FEATURES (when representable, e.g. NUM_FEATURES=12) -> out_err=1 after 1 cycle.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_class stable, in_ready=0, cfg_we writing n1 class 3 ignored; next run still class 5.
- Assert rst_n=0 mid-WALK -> out_valid=0, in_ready=1 immediately; table retained, next vector classifies correctly.

Source files
------------

// File: rtl/dtree_seq_classifier.sv
// ---------------------------------------------------------------------------
// dtree_seq_classifier
//
// Sequential, table-driven decision-tree classifier. A feature vector is
// accepted over a valid/ready handshake. The tree is then walked one node per
// clock, starting at node 0, until a leaf is reached. The leaf's class is
// presented over a second valid/ready handshake. The node table is a
// runtime-writable register array. It can be written only while the block is
// idle.
//
// Node word layout, MSB to LSB:
//   leaf(1) | feat_idx(FIW) | thr(FEAT_W) | left(NODE_AW) | right(NODE_AW)
// A leaf node's class is thr[CLASS_W-1:0].
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_we/addr/wdata   node table write port, honoured only when cfg_ready
//   cfg_ready           high in IDLE
//   in_valid/in_ready   feature vector handshake
//   in_feat             feature i at bits [i*FEAT_W +: FEAT_W]
//   out_valid/out_ready result handshake
//   out_class           predicted class
//   out_err             walk aborted (depth overrun or bad feature index)
//
// Optional build macro DTREE_PATH_TRACE_EN adds these outputs:
//   out_depth           internal nodes evaluated for the current result
//   out_leaf            index of the final node evaluated
// ---------------------------------------------------------------------------
module dtree_seq_classifier #(
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_W       = 8,
    parameter int CLASS_W      = 4,
    parameter int NODE_AW      = 6,
    parameter int MAX_DEPTH    = 8,
    localparam int FIW     = ($clog2(NUM_FEATURES) < 1) ? 1 : $clog2(NUM_FEATURES),
    localparam int NODE_W  = 1 + FIW + FEAT_W + 2 * NODE_AW,
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_we,
    input  logic [NODE_AW-1:0]             cfg_addr,
    input  logic [NODE_W-1:0]              cfg_wdata,
    output logic                           cfg_ready,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_FEATURES*FEAT_W-1:0] in_feat,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CLASS_W-1:0]             out_class,
`ifdef DTREE_PATH_TRACE_EN
    output logic [DEPTH_W-1:0]             out_depth,
    output logic [NODE_AW-1:0]             out_leaf,
`endif
    output logic                           out_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, DONE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [NODE_AW-1:0]    ptr_q, ptr_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [CLASS_W-1:0]    class_q, class_d;
    logic                  err_q, err_d;
    logic [FEAT_W-1:0]     feat_q [NUM_FEATURES];
    logic [FEAT_W-1:0]     feat_d [NUM_FEATURES];
    logic [NODE_W-1:0]     node_mem [2**NODE_AW];

    // Fields of the node currently addressed by the walk pointer.
    logic [NODE_W-1:0]     node;
    logic                  node_leaf;
    logic [FIW-1:0]        node_idx;
    logic [FEAT_W-1:0]     node_thr;
    logic [NODE_AW-1:0]    node_left;
    logic [NODE_AW-1:0]    node_right;
    logic [FEAT_W-1:0]     feat_sel;
    logic                  idx_ok;

    always_comb begin
        node       = node_mem[ptr_q];
        node_leaf  = node[NODE_W-1];
        node_idx   = node[NODE_W-2 -: FIW];
        node_thr   = node[2*NODE_AW +: FEAT_W];
        node_left  = node[NODE_AW +: NODE_AW];
        node_right = node[0 +: NODE_AW];
        // The index field may encode values beyond NUM_FEATURES. Decode it
        // explicitly so that an out-of-range index selects zero instead of
        // indexing past the end of the array.
        feat_sel = '0;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (node_idx == FIW'(i)) feat_sel = feat_q[i];
        end
        idx_ok = ({1'b0, node_idx} < (FIW+1)'(NUM_FEATURES));
    end

    // Input vector capture. This is data only, so it has no reset.
    always_comb begin
        for (int i = 0; i < NUM_FEATURES; i++) begin
            feat_d[i] = (state_q == IDLE && in_valid) ? in_feat[i*FEAT_W +: FEAT_W] : feat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        feat_q <= feat_d;
    end

    // The table is not reset; it keeps its contents across rst_n.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == IDLE) node_mem[cfg_addr] <= cfg_wdata;
    end

    // State register and walk control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            depth_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            class_q <= class_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. The walk evaluates one node per cycle. The abort
    // checks precede the depth increment, so depth never exceeds MAX_DEPTH.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        class_d = class_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = WALK;
                    ptr_d   = '0;
                    depth_d = '0;
                end
            end
            WALK: begin
                if (node_leaf) begin
                    class_d = node_thr[CLASS_W-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (depth_q == DEPTH_W'(MAX_DEPTH) || !idx_ok) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ptr_d   = (feat_sel <= node_thr) ? node_left : node_right;
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready  = (state_q == IDLE);
        cfg_ready = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_class = class_q;
        out_err   = err_q;
`ifdef DTREE_PATH_TRACE_EN
        // A terminal node leaves the pointer and depth untouched, so these
        // registers already describe the finished walk.
        out_depth = depth_q;
        out_leaf  = ptr_q;
`endif
    end

endmodule

// File: tb/tb_dtree_seq_classifier.sv
module tb_dtree_seq_classifier;

    localparam int NF      = 12;
    localparam int FW      = 8;
    localparam int CW      = 4;
    localparam int AW      = 6;
    localparam int MD      = 8;
    localparam int FIW     = 4;
    localparam int NW      = 1 + FIW + FW + 2 * AW;
    localparam int DEPTH_W = 4;

    logic              clk;
    logic              rst_n;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [NW-1:0]     cfg_wdata;
    logic              cfg_ready;
    logic              in_valid;
    logic              in_ready;
    logic [NF*FW-1:0]  in_feat;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_class;
    logic              out_err;
`ifdef DTREE_PATH_TRACE_EN
    logic [DEPTH_W-1:0] out_depth;
    logic [AW-1:0]      out_leaf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [FW-1:0] feat_v [NF];

    dtree_seq_classifier #(
        .NUM_FEATURES(NF), .FEAT_W(FW), .CLASS_W(CW), .NODE_AW(AW), .MAX_DEPTH(MD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
`ifdef DTREE_PATH_TRACE_EN
        .out_depth(out_depth), .out_leaf(out_leaf),
`endif
        .out_err(out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [NW-1:0] mk(input logic lf, input logic [FIW-1:0] idx,
                                         input logic [FW-1:0] thr, input logic [AW-1:0] l,
                                         input logic [AW-1:0] r);
        return {lf, idx, thr, l, r};
    endfunction

    task automatic clear_feat();
        for (int i = 0; i < NF; i++) feat_v[i] = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NW-1:0] d);
        int n;
        @(negedge clk);
        n = 0;
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Presents feat_v and returns the cycles from the accept edge to out_valid
    // (-1 if the vector was not accepted or no result arrived within the bound).
    task automatic send(output int lat, output logic [CW-1:0] cls, output logic err);
        int n;
        lat = -1; cls = '0; err = 1'b0;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) return;
        for (int i = 0; i < NF; i++) in_feat[i*FW +: FW] = feat_v[i];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k; cls = out_class; err = out_err;
                break;
            end
        end
    endtask

    task automatic load_tree();
        wr(0, mk(1'b0, 4'd2, 8'd100, 6'd1, 6'd2));
        wr(1, mk(1'b1, 4'd0, 8'd5,   6'd0, 6'd0));
        wr(2, mk(1'b0, 4'd0, 8'd200, 6'd3, 6'd4));
        wr(3, mk(1'b1, 4'd0, 8'd7,   6'd0, 6'd0));
        wr(4, mk(1'b1, 4'd0, 8'd9,   6'd0, 6'd0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_class !== 4'd0) begin n_fail++; $display("FAIL reset_out_class: got %0d expected 0", out_class); end
        n_tests++; if (out_err !== 1'b0)   begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic [CW-1:0] c; logic e;
        load_tree();
        clear_feat(); feat_v[2] = 8'd100;
        send(lat, c, e);
        n_tests++; if (c !== 4'd5)  begin n_fail++; $display("FAIL basic_eq_class: got %0d expected 5", c); end
        n_tests++; if (e !== 1'b0)  begin n_fail++; $display("FAIL basic_eq_err: got %b expected 0", e); end
        n_tests++; if (lat !== 2)   begin n_fail++; $display("FAIL basic_eq_latency: got %0d expected 2", lat); end
        clear_feat(); feat_v[2] = 8'd0; feat_v[0] = 8'd250;
        send(lat, c, e);
        n_tests++; if (c !== 4'd5)  begin n_fail++; $display("FAIL basic_zero_class: got %0d expected 5", c); end
        n_tests++; if (lat !== 2)   begin n_fail++; $display("FAIL basic_zero_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_threshold();
        int lat; logic [CW-1:0] c; logic e;
        clear_feat(); feat_v[2] = 8'd101; feat_v[0] = 8'd200;
        send(lat, c, e);
        n_tests++; if (c !== 4'd7)  begin n_fail++; $display("FAIL thr_eq_class: got %0d expected 7", c); end
        n_tests++; if (e !== 1'b0)  begin n_fail++; $display("FAIL thr_eq_err: got %b expected 0", e); end
        n_tests++; if (lat !== 3)   begin n_fail++; $display("FAIL thr_eq_latency: got %0d expected 3", lat); end
        feat_v[0] = 8'd201;
        send(lat, c, e);
        n_tests++; if (c !== 4'd9)  begin n_fail++; $display("FAIL thr_gt_class: got %0d expected 9", c); end
        n_tests++; if (e !== 1'b0)  begin n_fail++; $display("FAIL thr_gt_err: got %b expected 0", e); end
        n_tests++; if (lat !== 3)   begin n_fail++; $display("FAIL thr_gt_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_top_index();
        int lat; logic [CW-1:0] c; logic e;
        wr(0, mk(1'b0, 4'd11, 8'd50, 6'd1, 6'd2));
        clear_feat(); feat_v[11] = 8'd50;
        send(lat, c, e);
        n_tests++; if (c !== 4'd5)  begin n_fail++; $display("FAIL idx11_left_class: got %0d expected 5", c); end
        n_tests++; if (lat !== 2)   begin n_fail++; $display("FAIL idx11_left_latency: got %0d expected 2", lat); end
        feat_v[11] = 8'd51;
        send(lat, c, e);
        n_tests++; if (c !== 4'd7)  begin n_fail++; $display("FAIL idx11_right_class: got %0d expected 7", c); end
        n_tests++; if (lat !== 3)   begin n_fail++; $display("FAIL idx11_right_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_bad_index();
        int lat; logic [CW-1:0] c; logic e;
        wr(0, mk(1'b0, 4'd12, 8'd255, 6'd1, 6'd2));
        clear_feat();
        send(lat, c, e);
        n_tests++; if (e !== 1'b1)  begin n_fail++; $display("FAIL badidx_err: got %b expected 1", e); end
        n_tests++; if (c !== 4'd0)  begin n_fail++; $display("FAIL badidx_class: got %0d expected 0", c); end
        n_tests++; if (lat !== 1)   begin n_fail++; $display("FAIL badidx_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_depth_overrun();
        int lat; logic [CW-1:0] c; logic e;
        wr(0, mk(1'b0, 4'd0, 8'd255, 6'd0, 6'd0));
        clear_feat(); feat_v[0] = 8'd17;
        send(lat, c, e);
        n_tests++; if (e !== 1'b1)  begin n_fail++; $display("FAIL overrun_err: got %b expected 1", e); end
        n_tests++; if (c !== 4'd0)  begin n_fail++; $display("FAIL overrun_class: got %0d expected 0", c); end
        n_tests++; if (lat !== 9)   begin n_fail++; $display("FAIL overrun_latency: got %0d expected 9", lat); end
`ifdef DTREE_PATH_TRACE_EN
        n_tests++; if (out_depth !== 4'd8) begin n_fail++; $display("FAIL overrun_depth: got %0d expected 8", out_depth); end
        n_tests++; if (out_leaf !== 6'd0)  begin n_fail++; $display("FAIL overrun_leaf: got %0d expected 0", out_leaf); end
`endif
        wr(0, mk(1'b0, 4'd2, 8'd100, 6'd1, 6'd2));
    endtask

    task automatic test_backpressure();
        int lat; logic [CW-1:0] c; logic e;
        out_ready = 1'b0;
        clear_feat(); feat_v[2] = 8'd10;
        send(lat, c, e);
        n_tests++; if (c !== 4'd5)  begin n_fail++; $display("FAIL bp_class: got %0d expected 5", c); end
        n_tests++; if (lat !== 2)   begin n_fail++; $display("FAIL bp_latency: got %0d expected 2", lat); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = mk(1'b1, 4'd0, 8'd3, 6'd0, 6'd0);
            end else begin
                cfg_we = 1'b0;
            end
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, out_valid); end
            n_tests++; if (out_class !== 4'd5) begin n_fail++; $display("FAIL bp_hold_class[%0d]: got %0d expected 5", k, out_class); end
            n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", k, in_ready); end
            n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_cfg_ready[%0d]: got %b expected 0", k, cfg_ready); end
        end
        out_ready = 1'b1;
        send(lat, c, e);
        n_tests++; if (c !== 4'd5)  begin n_fail++; $display("FAIL bp_cfg_ignored_class: got %0d expected 5", c); end
    endtask

    task automatic test_reset_mid_walk();
        int lat; logic [CW-1:0] c; logic e; int n;
        clear_feat(); feat_v[2] = 8'd101; feat_v[0] = 8'd200;
        for (int i = 0; i < NF; i++) in_feat[i*FW +: FW] = feat_v[i];
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstwalk_busy: got %b expected 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstwalk_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rstwalk_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rstwalk_cfg_ready: got %b expected 1", cfg_ready); end
        n_tests++; if (out_class !== 4'd0) begin n_fail++; $display("FAIL rstwalk_out_class: got %0d expected 0", out_class); end
        n_tests++; if (out_err !== 1'b0)   begin n_fail++; $display("FAIL rstwalk_out_err: got %b expected 0", out_err); end
        @(negedge clk);
        rst_n = 1'b1;
        feat_v[0] = 8'd201;
        send(lat, c, e);
        n_tests++; if (c !== 4'd9)  begin n_fail++; $display("FAIL rstwalk_after_class: got %0d expected 9", c); end
        n_tests++; if (e !== 1'b0)  begin n_fail++; $display("FAIL rstwalk_after_err: got %b expected 0", e); end
        n_tests++; if (lat !== 3)   begin n_fail++; $display("FAIL rstwalk_after_latency: got %0d expected 3", lat); end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b1;
        clear_feat();
        test_reset();
        test_basic();
        test_threshold();
        test_top_index();
        test_bad_index();
        test_depth_overrun();
        test_backpressure();
        test_reset_mid_walk();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
